// File: rtl/regfile_mp.sv
// regfile_mp -- parametrised multi-port integer register file with busy scoreboard.
//
// Sits between ID (reads operands, allocates destinations) and WB (writes and
// retires results). Two write ports serve the dual-retire path. A per-register
// busy bit tells the hazard unit that a write to that register is still pending.
//
// Parameters:
//   DATA_W   register width in bits
//   ADDR_W   address width, depth = 2**ADDR_W
//   NUM_RD   number of read ports (1..4)
//   BYPASS   1 = reads see same-cycle write data, 0 = reads see stored value
//   ZERO_REG 1 = register 0 is hardwired to zero and never busy
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   rd_addr / rd_data        packed read ports, port k at slice k (combinational)
//   rd_busy                  per read port: addressed register has a write pending
//   wr0_* / wr1_*            write ports; wr1 wins on an address collision
//   alloc_en / alloc_addr    mark a destination register busy
//   busy_vec                 full registered scoreboard

module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr0_en,
  input  logic [ADDR_W-1:0]          wr0_addr,
  input  logic [DATA_W-1:0]          wr0_data,
  input  logic                       wr1_en,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [DATA_W-1:0]          wr1_data,
  input  logic                       alloc_en,
  input  logic [ADDR_W-1:0]          alloc_addr,
  output logic [(2**ADDR_W)-1:0]     busy_vec
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit UseBypass = (BYPASS != 0);
  localparam bit UseZero = (ZERO_REG != 0);

  // Reject configurations the read mux and packing were not built for.
  if (NUM_RD < 1 || NUM_RD > 4 || DATA_W < 1) begin : gBadParams
    $fatal(1, "regfile_mp: NUM_RD must be 1..4 and DATA_W must be >= 1");
  end

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busyNext;
  logic              wr0Ok;
  logic              wr1Ok;

  // A write to the hardwired zero register is dropped before it reaches the array.
  always_comb begin
    wr0Ok = wr0_en && !(UseZero && (wr0_addr == '0));
    wr1Ok = wr1_en && !(UseZero && (wr1_addr == '0));
  end

  // Register array. wr1 is applied after wr0 so it wins an address collision,
  // matching the younger instruction retiring on port 1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wr0Ok) begin
        regs[wr0_addr] <= wr0_data;
      end
      if (wr1Ok) begin
        regs[wr1_addr] <= wr1_data;
      end
    end
  end

  // Scoreboard next state. Retiring writes clear, then an alloc sets, so a new
  // producer issued in the same cycle supersedes the one retiring.
  always_comb begin
    busyNext = busy;
    for (int r = 0; r < DEPTH; r++) begin
      if ((wr0_en && (wr0_addr == ADDR_W'(r))) ||
          (wr1_en && (wr1_addr == ADDR_W'(r)))) begin
        busyNext[r] = 1'b0;
      end
      if (alloc_en && (alloc_addr == ADDR_W'(r))) begin
        busyNext[r] = 1'b1;
      end
    end
    if (UseZero) begin
      busyNext[0] = 1'b0;
    end
  end

  // Scoreboard register; reset discards every pending producer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busyNext;
    end
  end

  assign busy_vec = busy;

  // Read ports. Each port resolves zero-register, then wr1 forward, then wr0
  // forward, then the stored value. A register being forwarded this cycle is
  // reported not busy because the consumer already has its value.
  for (genvar k = 0; k < NUM_RD; k++) begin : gRead
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busyOut;
    logic              hit0;
    logic              hit1;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      hit0    = wr0_en && (wr0_addr == addr);
      hit1    = wr1_en && (wr1_addr == addr);
      data    = regs[addr];
      busyOut = busy[addr];
      if (UseZero && (addr == '0)) begin
        data = '0;
      end else if (UseBypass && hit1) begin
        data = wr1_data;
      end else if (UseBypass && hit0) begin
        data = wr0_data;
      end
      if (UseBypass && (hit0 || hit1)) begin
        busyOut = 1'b0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
    assign rd_busy[k] = busyOut;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp -- scoreboard bench for regfile_mp.
//
// Two builds share one stimulus stream: dutA is the default 32-bit, 2-port
// bypassing register file, dutB is a 64-bit, 4-port build without bypass.
// A driver applies one stimulus per cycle, predicts both builds' outputs from a
// behavioural model, and queues the prediction; a monitor on the falling edge
// pops each prediction and compares it against the live DUT outputs.

module tb_regfile_mp;

  typedef struct {
    logic            rst;
    logic            wr0En;
    logic [4:0]      wr0Addr;
    logic [63:0]     wr0Data;
    logic            wr1En;
    logic [4:0]      wr1Addr;
    logic [63:0]     wr1Data;
    logic            allocEn;
    logic [4:0]      allocAddr;
    logic [3:0][4:0] rdAddr;
  } stim_t;

  typedef struct {
    int               cyc;
    logic [1:0][31:0] dataA;
    logic [1:0]       busyA;
    logic [3:0][63:0] dataB;
    logic [3:0]       busyB;
    logic [31:0]      vec;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [3:0][4:0]  rdAddr;
  logic             wr0En;
  logic [4:0]       wr0Addr;
  logic [63:0]      wr0Data;
  logic             wr1En;
  logic [4:0]       wr1Addr;
  logic [63:0]      wr1Data;
  logic             allocEn;
  logic [4:0]       allocAddr;

  logic [1:0][31:0] rdDataA;
  logic [1:0]       rdBusyA;
  logic [31:0]      busyVecA;
  logic [3:0][63:0] rdDataB;
  logic [3:0]       rdBusyB;
  logic [31:0]      busyVecB;

  // Behavioural model: plain arrays of register contents and pending flags.
  logic [63:0] memM [32];
  logic        busyM [32];

  exp_t expQ [$];
  int   testsRun;
  int   failures;
  int   cycleCnt;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) dutA (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rdAddr[1:0]),
    .rd_data    (rdDataA),
    .rd_busy    (rdBusyA),
    .wr0_en     (wr0En),
    .wr0_addr   (wr0Addr),
    .wr0_data   (wr0Data[31:0]),
    .wr1_en     (wr1En),
    .wr1_addr   (wr1Addr),
    .wr1_data   (wr1Data[31:0]),
    .alloc_en   (allocEn),
    .alloc_addr (allocAddr),
    .busy_vec   (busyVecA)
  );

  regfile_mp #(.DATA_W(64), .ADDR_W(5), .NUM_RD(4), .BYPASS(0), .ZERO_REG(1)) dutB (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rdAddr),
    .rd_data    (rdDataB),
    .rd_busy    (rdBusyB),
    .wr0_en     (wr0En),
    .wr0_addr   (wr0Addr),
    .wr0_data   (wr0Data),
    .wr1_en     (wr1En),
    .wr1_addr   (wr1Addr),
    .wr1_data   (wr1Data),
    .alloc_en   (allocEn),
    .alloc_addr (allocAddr),
    .busy_vec   (busyVecB)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Overall time limit so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation time limit reached, %0d predictions pending", expQ.size());
    $fatal(1, "[TB] timeout");
  end

  function automatic stim_t idleStim();
    stim_t s;
    s.rst       = 1'b1;
    s.wr0En     = 1'b0;
    s.wr0Addr   = '0;
    s.wr0Data   = '0;
    s.wr1En     = 1'b0;
    s.wr1Addr   = '0;
    s.wr1Data   = '0;
    s.allocEn   = 1'b0;
    s.allocAddr = '0;
    s.rdAddr    = '0;
    return s;
  endfunction

  // What a read port should return this cycle, from the model plus live writes.
  function automatic logic [63:0] modelRead(stim_t s, logic [4:0] a, bit bypass);
    if (a == 5'd0) return 64'd0;
    if (bypass && s.wr1En && s.wr1Addr == a) return s.wr1Data;
    if (bypass && s.wr0En && s.wr0Addr == a) return s.wr0Data;
    return memM[a];
  endfunction

  function automatic logic modelBusy(stim_t s, logic [4:0] a, bit bypass);
    bit retiring;
    retiring = (s.wr0En && s.wr0Addr == a) || (s.wr1En && s.wr1Addr == a);
    if (a == 5'd0) return 1'b0;
    if (bypass && retiring) return 1'b0;
    return busyM[a];
  endfunction

  // Advance the model by one clock edge.
  task automatic modelUpdate(stim_t s);
    if (!s.rst) begin
      for (int i = 0; i < 32; i++) begin
        memM[i]  = '0;
        busyM[i] = 1'b0;
      end
    end else begin
      if (s.wr0En && s.wr0Addr != 0) memM[s.wr0Addr] = s.wr0Data;
      if (s.wr1En && s.wr1Addr != 0) memM[s.wr1Addr] = s.wr1Data;
      if (s.wr0En) busyM[s.wr0Addr] = 1'b0;
      if (s.wr1En) busyM[s.wr1Addr] = 1'b0;
      if (s.allocEn && s.allocAddr != 0) busyM[s.allocAddr] = 1'b1;
    end
  endtask

  // Drive one cycle of stimulus, queue the predicted outputs, then step the model.
  task automatic applyStimulus(stim_t s);
    exp_t        e;
    logic [63:0] v;
    @(posedge clk);
    #1;
    rst       = s.rst;
    wr0En     = s.wr0En;
    wr0Addr   = s.wr0Addr;
    wr0Data   = s.wr0Data;
    wr1En     = s.wr1En;
    wr1Addr   = s.wr1Addr;
    wr1Data   = s.wr1Data;
    allocEn   = s.allocEn;
    allocAddr = s.allocAddr;
    rdAddr    = s.rdAddr;
    e.cyc = cycleCnt;
    for (int k = 0; k < 2; k++) begin
      v = modelRead(s, s.rdAddr[k], 1'b1);
      e.dataA[k] = v[31:0];
      e.busyA[k] = modelBusy(s, s.rdAddr[k], 1'b1);
    end
    for (int k = 0; k < 4; k++) begin
      e.dataB[k] = modelRead(s, s.rdAddr[k], 1'b0);
      e.busyB[k] = modelBusy(s, s.rdAddr[k], 1'b0);
    end
    for (int i = 0; i < 32; i++) begin
      e.vec[i] = busyM[i];
    end
    expQ.push_back(e);
    cycleCnt++;
    modelUpdate(s);
  endtask

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] req);
    testsRun++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every falling edge with a pending prediction compares it to the DUTs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        for (int k = 0; k < 2; k++) begin
          checkOutput($sformatf("A.rd_data%0d c%0d", k, e.cyc), 64'(rdDataA[k]), 64'(e.dataA[k]));
          checkOutput($sformatf("A.rd_busy%0d c%0d", k, e.cyc), 64'(rdBusyA[k]), 64'(e.busyA[k]));
        end
        for (int k = 0; k < 4; k++) begin
          checkOutput($sformatf("B.rd_data%0d c%0d", k, e.cyc), rdDataB[k], e.dataB[k]);
          checkOutput($sformatf("B.rd_busy%0d c%0d", k, e.cyc), 64'(rdBusyB[k]), 64'(e.busyB[k]));
        end
        checkOutput($sformatf("A.busy_vec c%0d", e.cyc), 64'(busyVecA), 64'(e.vec));
        checkOutput($sformatf("B.busy_vec c%0d", e.cyc), 64'(busyVecB), 64'(e.vec));
      end
    end
  end

  // Stimulus: directed scenarios followed by a randomized stream.
  initial begin
    stim_t s;
    testsRun = 0;
    failures = 0;
    cycleCnt = 0;
    for (int i = 0; i < 32; i++) begin
      memM[i]  = '0;
      busyM[i] = 1'b0;
    end
    rst = 1'b0; wr0En = 1'b0; wr1En = 1'b0; allocEn = 1'b0;
    wr0Addr = '0; wr1Addr = '0; allocAddr = '0; wr0Data = '0; wr1Data = '0; rdAddr = '0;
    repeat (2) @(posedge clk);
    $display("[TB] starting regfile_mp scoreboard run");

    // Right after reset: everything reads zero and nothing is busy.
    for (int i = 0; i < 8; i++) begin
      s = idleStim();
      for (int k = 0; k < 4; k++) s.rdAddr[k] = 5'(4 * i + k);
      applyStimulus(s);
    end

    // Load every register with a nonzero value and leave busy bits pending.
    for (int i = 0; i < 32; i++) begin
      s = idleStim();
      s.wr0En = 1'b1; s.wr0Addr = 5'(i); s.wr0Data = {$urandom, $urandom} | 64'd1;
      s.allocEn = 1'b1; s.allocAddr = 5'((i + 7) % 32);
      s.rdAddr[0] = 5'(i); s.rdAddr[1] = 5'((i + 1) % 32);
      applyStimulus(s);
    end

    // Two reset cycles with writes and alloc active; those must be discarded.
    for (int i = 0; i < 2; i++) begin
      s = idleStim();
      s.rst = 1'b0;
      s.wr0En = 1'b1; s.wr0Addr = 5'd5; s.wr0Data = 64'h1234_5678_9ABC_DEF0;
      s.wr1En = 1'b1; s.wr1Addr = 5'd6; s.wr1Data = 64'h0FED_CBA9_8765_4321;
      s.allocEn = 1'b1; s.allocAddr = 5'd8;
      applyStimulus(s);
    end
    for (int i = 0; i < 8; i++) begin
      s = idleStim();
      for (int k = 0; k < 4; k++) s.rdAddr[k] = 5'(4 * i + k);
      applyStimulus(s);
    end

    // Basic write then read, and the zero register ignoring a write.
    s = idleStim(); s.wr0En = 1'b1; s.wr0Addr = 5'd5; s.wr0Data = 64'hDEAD_BEEF; applyStimulus(s);
    s = idleStim(); s.rdAddr[0] = 5'd5; s.wr0En = 1'b1; s.wr0Addr = 5'd0; s.wr0Data = 64'h1234;
    applyStimulus(s);
    s = idleStim(); s.rdAddr[0] = 5'd0; s.rdAddr[1] = 5'd5; applyStimulus(s);

    // Forwarding: x7 holds an old value and is busy; wr1 retires it while port 1 reads.
    s = idleStim(); s.allocEn = 1'b1; s.allocAddr = 5'd7;
    s.wr0En = 1'b1; s.wr0Addr = 5'd7; s.wr0Data = 64'h1111; applyStimulus(s);
    s = idleStim(); s.wr1En = 1'b1; s.wr1Addr = 5'd7; s.wr1Data = 64'hA5A5_A5A5;
    s.rdAddr[1] = 5'd7; s.rdAddr[3] = 5'd7; applyStimulus(s);
    s = idleStim(); s.rdAddr[1] = 5'd7; applyStimulus(s);

    // Write collision on x3 while it is busy: wr1 wins and busy clears.
    s = idleStim(); s.allocEn = 1'b1; s.allocAddr = 5'd3; applyStimulus(s);
    s = idleStim(); s.rdAddr[0] = 5'd3;
    s.wr0En = 1'b1; s.wr0Addr = 5'd3; s.wr0Data = 64'h11;
    s.wr1En = 1'b1; s.wr1Addr = 5'd3; s.wr1Data = 64'h22; applyStimulus(s);
    s = idleStim(); s.rdAddr[0] = 5'd3; s.rdAddr[2] = 5'd3; applyStimulus(s);

    // Scoreboard: alloc x9, alloc+write x9 keeps it busy, later wr1 clears it.
    s = idleStim(); s.allocEn = 1'b1; s.allocAddr = 5'd9; applyStimulus(s);
    s = idleStim(); s.rdAddr[0] = 5'd9; s.rdAddr[2] = 5'd9; applyStimulus(s);
    s = idleStim(); s.allocEn = 1'b1; s.allocAddr = 5'd9;
    s.wr0En = 1'b1; s.wr0Addr = 5'd9; s.wr0Data = 64'h99; applyStimulus(s);
    s = idleStim(); s.rdAddr[1] = 5'd9; s.rdAddr[3] = 5'd9; applyStimulus(s);
    s = idleStim(); s.wr1En = 1'b1; s.wr1Addr = 5'd9; s.wr1Data = 64'h9999; applyStimulus(s);
    s = idleStim(); s.rdAddr[0] = 5'd9; applyStimulus(s);

    // Alloc of the zero register is ignored.
    s = idleStim(); s.allocEn = 1'b1; s.allocAddr = 5'd0; applyStimulus(s);
    s = idleStim(); s.rdAddr[0] = 5'd0; applyStimulus(s);

    // Distinct 64-bit values in x1..x4 read back on four ports, with busy pending.
    for (int i = 1; i <= 4; i++) begin
      s = idleStim();
      s.wr0En = 1'b1; s.wr0Addr = 5'(i); s.wr0Data = {32'hC0DE_0000 + 32'(i), 32'h0BAD_F00D ^ 32'(i * 17)};
      s.allocEn = 1'b1; s.allocAddr = 5'(i + 10);
      applyStimulus(s);
    end
    s = idleStim();
    for (int k = 0; k < 4; k++) s.rdAddr[k] = 5'(k + 1);
    applyStimulus(s);

    // Reset mid-stream with pending busy bits, then confirm everything is clear.
    s = idleStim(); s.rst = 1'b0; s.allocEn = 1'b1; s.allocAddr = 5'd12; applyStimulus(s);
    s = idleStim();
    for (int k = 0; k < 4; k++) s.rdAddr[k] = 5'(k + 1);
    applyStimulus(s);
    s = idleStim(); s.rdAddr[0] = 5'd11; s.rdAddr[1] = 5'd14; applyStimulus(s);

    // Randomized stream biased toward address collisions and forwarding.
    for (int n = 0; n < 500; n++) begin
      s = idleStim();
      s.rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      s.wr0En = 1'($urandom_range(0, 1));
      s.wr0Addr = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      s.wr0Data = {$urandom, $urandom};
      s.wr1En = 1'($urandom_range(0, 1));
      s.wr1Addr = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      s.wr1Data = {$urandom, $urandom};
      s.allocEn = 1'($urandom_range(0, 1));
      s.allocAddr = 5'($urandom_range(0, 7));
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 3))
          0:       s.rdAddr[k] = s.wr0Addr;
          1:       s.rdAddr[k] = s.wr1Addr;
          default: s.rdAddr[k] = 5'($urandom_range(0, 7));
        endcase
      end
      applyStimulus(s);
    end

    // Let the monitor drain the remaining predictions, bounded.
    for (int i = 0; i < 10 && expQ.size() != 0; i++) @(posedge clk);
    if (expQ.size() != 0) begin
      testsRun++;
      failures++;
      $display("[TB] FAIL drain: %0d predictions left, expected 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; next-generation replacement for the single-write, two-read RF in the pipelined CPU.
- Adds configurable width, depth and read-port count, a second write port for the dual-retire path, and optional same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard that the hazard unit uses to stall on outstanding writes.
- Sits between ID (read/allocate) and WB (write/retire).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W registers
- NUM_RD, 2, number of read ports, legal 1..4
- BYPASS, 1, 1 = a read of a register being written this cycle returns the write data; 0 = returns the stored value
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational
- rd_busy  out  NUM_RD  1 = register addressed by port k has a write outstanding
- wr0_en  in  1  write-port-0 enable
- wr0_addr  in  ADDR_W  write-port-0 address
- wr0_data  in  DATA_W  write-port-0 data
- wr1_en  in  1  write-port-1 enable
- wr1_addr  in  ADDR_W  write-port-1 address
- wr1_data  in  DATA_W  write-port-1 data
- alloc_en  in  1  mark a register busy (destination of an issued instruction)
- alloc_addr  in  ADDR_W  register to mark busy
- busy_vec  out  2**ADDR_W  full scoreboard, registered

Behaviour:
- Reset (rst==0 at a rising edge):
  - All registers are cleared to 0 and all busy bits are cleared.
  - Writes and alloc in the same cycle are ignored.
  - Reset mid-operation discards all outstanding state.
- After reset, rd_data reflects the cleared array: all zeros. rd_busy=0 and busy_vec=0.
- Writes:
  - Take effect on the rising edge; new values are visible in the array from the next cycle.
  - wr0 and wr1 to the same address in the same cycle: wr1 wins (younger instruction). Both ports' busy effects are still applied.
  - ZERO_REG=1: writes to address 0 are dropped.
- Reads are combinational. For each port k, the priority is:
  1. ZERO_REG=1 and address 0 -> 0.
  2. BYPASS=1 and wr1_en and wr1_addr matches -> wr1_data.
  3. BYPASS=1 and wr0_en and wr0_addr matches -> wr0_data.
  4. Otherwise -> the stored register value.
- Scoreboard, per register r, updated on the rising edge:
  - set = alloc_en && alloc_addr==r
  - clr = (wr0_en && wr0_addr==r) || (wr1_en && wr1_addr==r)
  - next busy[r] = set ? 1 : (clr ? 0 : busy[r])
  - alloc takes priority over a clear in the same cycle: the new producer supersedes the retiring one.
  - ZERO_REG=1: busy[0] is held at 0 and alloc to address 0 is ignored.
- rd_busy[k] = busy[rd_addr_k] && !(BYPASS && a write to that address in the current cycle).
  - With BYPASS=1, a register retiring this cycle is reported not busy, because its value is being forwarded.
  - With BYPASS=0, rd_busy[k] reports busy[rd_addr_k] directly.
- A write to a register that is not busy is legal: it updates the data and leaves busy at 0.
- An alloc to a register that is already busy is legal: the register stays busy.
- No internal counters. Read latency is 0 cycles; write and scoreboard latency is 1 cycle.
- Parameter checks: NUM_RD outside 1..4, or DATA_W<1, is a fatal elaboration error.

Test Plan:
- Reset: drive rst=0 for 2 cycles after loading every register with a nonzero value -> all rd_data=0, busy_vec=0, and writes during reset have no effect.
- Write/read basic: wr0 writes x5=0xDEADBEEF; next cycle rd_addr0=5 -> 0xDEADBEEF. Writing x0=0x1234 -> reading x0 returns 0 (ZERO_REG=1).
- Bypass:
  - BYPASS=1: in the same cycle, wr1 writes x7=0xA5A5A5A5 while port 1 reads x7 -> rd_data1=0xA5A5A5A5 and rd_busy1=0.
  - Rebuild with BYPASS=0, same stimulus -> rd_data1 shows the old value that cycle and the new value the next cycle.
- Write collision: wr0 x3=0x11 and wr1 x3=0x22 in the same cycle -> x3 reads 0x22 thereafter, and x3's busy bit is cleared.
- Scoreboard:
  - alloc x9 -> busy_vec[9]=1 next cycle and rd_busy=1 when x9 is read.
  - alloc x9 and wr0 x9 in the same cycle -> busy_vec[9] stays 1.
  - A later wr1 x9 -> busy_vec[9]=0.
  - alloc x0 -> busy_vec[0] stays 0.
- NUM_RD=4, DATA_W=64 build: four ports read x1..x4 after distinct 64-bit writes -> each port returns its own value. Reset issued mid-stream with pending busy bits -> all busy bits and data clear.
